// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-address generator: chip enables, stall/branch
// flags and the 2-bit sequencer state.
package pc_gen_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    localparam logic BRANCH       = 1'b1;
    localparam logic NOT_BRANCH   = 1'b0;

    localparam logic [1:0] PCG_OFF  = 2'b00;
    localparam logic [1:0] PCG_BOOT = 2'b01;
    localparam logic [1:0] PCG_RUN  = 2'b10;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect target buffer: holds a branch target that arrived while
// fetch could not advance.
module pc_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] capture_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr
);

    // capture and clear are never raised together by pc_gen; capture is
    // checked first so a later branch simply overwrites the entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            addr  <= capture_addr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boot sequencing, flush/branch/pending redirect
// priority, sequential advance under stall and memory back-pressure.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC    = 32'h0000_0000,
    parameter int unsigned        FETCH_BYTES = 4,
    parameter int unsigned        STALL_W     = 6,
    parameter int unsigned        OFS_W       = $clog2(FETCH_BYTES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               imem_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending,
    output logic               misalign,
    output logic [ADDR_W-1:0]  misalign_addr
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

    logic [1:0]        state;
    logic              in_run;
    logic              adv;
    logic              apply;
    logic [ADDR_W-1:0] target;
    logic              buf_capture;
    logic [ADDR_W-1:0] buf_addr;
    logic              stall_unused;

    assign stall_unused = ^stall;

    assign in_run = (state == PCG_RUN);
    assign adv    = in_run && (stall[0] == NO_STOP) && imem_ready;

    always_comb begin
        apply  = 1'b0;
        target = new_pc;
        if (flush) begin
            apply  = in_run;
            target = new_pc;
        end else if (adv && (branch_flag_i == BRANCH)) begin
            apply  = 1'b1;
            target = branch_target_address_i;
        end else if (adv && redirect_pending) begin
            apply  = 1'b1;
            target = buf_addr;
        end
    end

    assign buf_capture = in_run && (branch_flag_i == BRANCH) && !adv && !flush;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk          (clk),
        .rst          (rst),
        .capture      (buf_capture),
        .clear        (apply),
        .capture_addr (branch_target_address_i),
        .valid        (redirect_pending),
        .addr         (buf_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= PCG_OFF;
            pc            <= RESET_PC;
            ce            <= CHIP_DISABLE;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                PCG_OFF: begin
                    state <= PCG_BOOT;
                    ce    <= CHIP_ENABLE;
                    pc    <= RESET_PC;
                end
                PCG_BOOT: begin
                    state <= PCG_RUN;
                end
                PCG_RUN: begin
                    if (apply) begin
                        pc <= target & ALIGN_MASK;
                        if (target[OFS_W-1:0] != '0) begin
                            misalign      <= 1'b1;
                            misalign_addr <= target;
                        end
                    end else if (adv) begin
                        pc <= pc + STEP;
                    end
                end
                default: begin
                    state <= PCG_OFF;
                    ce    <= CHIP_DISABLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboarded bench for pc_gen: boot, stalled branch, flush priority,
// back-pressure/wrap, misalignment (4- and 8-byte step) and async reset.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic        imem_ready;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    logic [31:0] mis_addr;

    logic [5:0]  stall8;
    logic        flush8;
    logic [31:0] new_pc8;
    logic        br8;
    logic [31:0] tgt8;
    logic        ready8;
    logic [31:0] pc8;
    logic        ce8;
    logic        pend8;
    logic        mis8;
    logic [31:0] mis_addr8;

    int unsigned n_checks;
    int unsigned n_err;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    pc_gen #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0000_0000),
        .FETCH_BYTES (4),
        .STALL_W     (6)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (br),
        .branch_target_address_i (tgt),
        .imem_ready              (imem_ready),
        .pc                      (pc),
        .ce                      (ce),
        .redirect_pending        (pend),
        .misalign                (mis),
        .misalign_addr           (mis_addr)
    );

    pc_gen #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0000_0000),
        .FETCH_BYTES (8),
        .STALL_W     (6)
    ) dut8 (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall8),
        .flush                   (flush8),
        .new_pc                  (new_pc8),
        .branch_flag_i           (br8),
        .branch_target_address_i (tgt8),
        .imem_ready              (ready8),
        .pc                      (pc8),
        .ce                      (ce8),
        .redirect_pending        (pend8),
        .misalign                (mis8),
        .misalign_addr           (mis_addr8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock once, then compare.
    task automatic cyc(input string tag, input logic [31:0] epc, input logic ece,
                       input logic epend, input logic emis);
        exp_t e;
        e.tag = tag; e.pc = epc; e.ce = ece; e.pend = epend; e.mis = emis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".pc"},   pc,          e.pc);
        check({e.tag, ".ce"},   32'(ce),     32'(e.ce));
        check({e.tag, ".pend"}, 32'(pend),   32'(e.pend));
        check({e.tag, ".mis"},  32'(mis),    32'(e.mis));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
        br = 1'b0; tgt = '0; imem_ready = 1'b1;
        stall8 = '0; flush8 = 1'b0; new_pc8 = '0; br8 = 1'b0; tgt8 = '0; ready8 = 1'b1;

        #1;
        check("reset.pc",   pc,        32'h0);
        check("reset.ce",   32'(ce),   32'h0);
        check("reset.pend", 32'(pend), 32'h0);
        check("reset.mis",  32'(mis),  32'h0);
        check("reset.maddr", mis_addr, 32'h0);
        for (int i = 0; i < 3; i++) cyc("rst_low", 32'h0, 1'b0, 1'b0, 1'b0);

        // Boot: BOOT cycle, first RUN cycle, then sequential advance.
        rst = 1'b1;
        cyc("boot",  32'h0, 1'b1, 1'b0, 1'b0);
        cyc("run0",  32'h0, 1'b1, 1'b0, 1'b0);
        cyc("seq4",  32'h4, 1'b1, 1'b0, 1'b0);
        cyc("seq8",  32'h8, 1'b1, 1'b0, 1'b0);
        cyc("seqC",  32'hC, 1'b1, 1'b0, 1'b0);

        // Branch during stall is buffered, then applied when stall drops.
        stall = 6'b000001;
        cyc("stall1", 32'hC, 1'b1, 1'b0, 1'b0);
        br = 1'b1; tgt = 32'h100;
        cyc("stcap",  32'hC, 1'b1, 1'b1, 1'b0);
        br = 1'b0;
        cyc("sthold", 32'hC, 1'b1, 1'b1, 1'b0);
        stall = '0;
        cyc("stapp",  32'h100, 1'b1, 1'b0, 1'b0);
        cyc("st104",  32'h104, 1'b1, 1'b0, 1'b0);

        // Flush beats a live branch and a pending target.
        stall = 6'b000001; br = 1'b1; tgt = 32'h100;
        cyc("flpend", 32'h104, 1'b1, 1'b1, 1'b0);
        flush = 1'b1; new_pc = 32'h20; tgt = 32'h300;
        cyc("flush",  32'h20, 1'b1, 1'b0, 1'b0);
        flush = 1'b0; br = 1'b0; stall = '0;
        cyc("fl24",   32'h24, 1'b1, 1'b0, 1'b0);
        cyc("fl28",   32'h28, 1'b1, 1'b0, 1'b0);

        // Back-pressure hold and modulo wrap.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        cyc("wrapld", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        flush = 1'b0; imem_ready = 1'b0;
        cyc("bp1",    32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        cyc("bp2",    32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        imem_ready = 1'b1;
        cyc("wrap0",  32'h0, 1'b1, 1'b0, 1'b0);
        cyc("wrap4",  32'h4, 1'b1, 1'b0, 1'b0);

        // Misaligned live branch.
        br = 1'b1; tgt = 32'h102;
        cyc("mis",    32'h100, 1'b1, 1'b0, 1'b1);
        check("mis.maddr", mis_addr, 32'h102);
        br = 1'b0;
        cyc("mis1",   32'h104, 1'b1, 1'b0, 1'b0);
        cyc("mis2",   32'h108, 1'b1, 1'b0, 1'b0);

        // Overwrite: youngest pending wins; alignment checked at apply time.
        stall = 6'b000001; br = 1'b1; tgt = 32'h400;
        cyc("ow1",    32'h108, 1'b1, 1'b1, 1'b0);
        tgt = 32'h502;
        cyc("ow2",    32'h108, 1'b1, 1'b1, 1'b0);
        br = 1'b0; stall = '0;
        cyc("owapp",  32'h500, 1'b1, 1'b0, 1'b1);
        check("ow.maddr", mis_addr, 32'h502);
        cyc("ow504",  32'h504, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with a pending redirect.
        stall = 6'b000001; br = 1'b1; tgt = 32'h600;
        cyc("arpend", 32'h504, 1'b1, 1'b1, 1'b0);
        br = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async.pc",    pc,        32'h0);
        check("async.ce",    32'(ce),   32'h0);
        check("async.pend",  32'(pend), 32'h0);
        check("async.maddr", mis_addr,  32'h0);
        stall = '0;
        cyc("arlow",  32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("arboot", 32'h0, 1'b1, 1'b0, 1'b0);
        cyc("arrun",  32'h0, 1'b1, 1'b0, 1'b0);

        // 8-byte step instance: 0x104 is misaligned for an 8-byte fetch.
        br8 = 1'b1; tgt8 = 32'h104;
        cyc("ar4",    32'h4, 1'b1, 1'b0, 1'b0);
        check("w8.pc",    pc8,        32'h100);
        check("w8.mis",   32'(mis8),  32'h1);
        check("w8.maddr", mis_addr8,  32'h104);
        br8 = 1'b0;
        cyc("ar8",    32'h8, 1'b1, 1'b0, 1'b0);
        check("w8.pc1",   pc8,        32'h108);
        check("w8.mis1",  32'(mis8),  32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-address generator and successor to the single-width PC register. It produces the instruction-fetch address and the fetch chip enable for the IF stage. New capabilities: a configurable reset vector and fetch step, a valid/ready handshake with the instruction memory, and a one-entry pending-redirect buffer, so a branch that arrives during a stall is not lost. Redirect targets are alignment-checked.

Parameters:
ADDR_W, 32, width of pc and of all target addresses
RESET_PC, 32'h0000_0000, value of pc at reset and on the first enabled cycle
FETCH_BYTES, 4, sequential increment; must be 4 or 8
STALL_W, 6, width of the stall vector from ctrl; only bit 0 is used
OFS_W, derived = log2(FETCH_BYTES), number of pc low bits that must be zero

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  pipeline stall vector from ctrl; stall[0]=1 freezes pc
flush  in  1  exception flush from ctrl
new_pc  in  ADDR_W  exception handler target, used when flush=1
branch_flag_i  in  1  branch taken, from ID
branch_target_address_i  in  ADDR_W  branch target
imem_ready  in  1  instruction memory accepts the current request this cycle
pc  out  ADDR_W  current fetch address
ce  out  1  fetch request valid (chip enable)
redirect_pending  out  1  pending-redirect buffer occupied
misalign  out  1  one-cycle pulse: an applied redirect target had nonzero low OFS_W bits
misalign_addr  out  ADDR_W  raw target captured at the last misalign pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - State becomes S_OFF.
  - Outputs: pc=RESET_PC, ce=0, redirect_pending=0, misalign=0, misalign_addr=0.
  - Pending buffer is cleared.
  - Reset asserted mid-operation discards any pending redirect immediately.
- FSM states are S_OFF, S_BOOT, S_RUN.
  - S_OFF: ce=0. Moves to S_BOOT on the first clock edge after rst is released.
  - S_BOOT: ce=1, pc=RESET_PC. Moves to S_RUN on the next edge. The first fetch is RESET_PC, one cycle after reset release.
  - S_RUN: ce=1. Never leaves except through reset.
- Advance condition: adv = (state==S_RUN) && !stall[0] && imem_ready.
- pc update each edge while in S_RUN, in strict priority order:
  1. flush=1: pc<=new_pc, and the pending buffer is cleared. Applies regardless of stall or imem_ready.
  2. adv && branch_flag_i: pc<=branch_target_address_i, and the pending buffer is cleared.
  3. adv && redirect_pending: pc<=pending target, and the pending buffer is cleared.
  4. adv: pc<=pc+FETCH_BYTES, computed modulo 2^ADDR_W (all-ones minus step+1 wraps to 0).
  5. Otherwise pc holds.
- Pending capture:
  - Trigger: branch_flag_i=1 && !adv && !flush, while in S_RUN.
  - Action: the buffer stores branch_target_address_i and redirect_pending goes to 1.
  - A second branch while the buffer is full overwrites it; the youngest target wins.
  - flush on the same edge as a capture: flush wins and nothing is stored.
- Alignment:
  - Every applied redirect (flush, live branch or pending) loads the target with its low OFS_W bits forced to 0.
  - If those bits were nonzero, misalign=1 for exactly the following cycle and misalign_addr<=raw target.
  - Misalignment is checked when the target is applied, not when it is captured.
- ce stays 1 during stall; stall only freezes pc. Memory back-pressure (imem_ready=0) holds both pc and ce.
- A combinational path from imem_ready to pc is forbidden. pc, ce, misalign and redirect_pending are all registered.

Decomposition:
- The shared defines header carries:
  - chip enable/disable constants;
  - Stop/NoStop and Branch encodings;
  - an FSM state encoding, PCG_OFF/PCG_BOOT/PCG_RUN, 2 bits.
- One natural sub-module, pc_redirect_buf. It holds the one-entry target register and its valid bit, with capture, clear and overwrite ports. The next-pc priority mux stays in pc_gen.

Test Plan:
- Reset release: rst low 3 cycles, then high, stall=0, imem_ready=1, RESET_PC=0. Required: cycle 1 ce=1, pc=0; then pc=0x4, 0x8, 0xC on successive cycles.
- Stalled branch: stall[0]=1 for 3 cycles, branch_flag_i=1 for 1 cycle in that window with target 0x100. Required: redirect_pending=1 and pc frozen; on the first cycle after stall drops, pc=0x100; then pc=0x104 and pending=0.
- Flush beats everything: pending=0x100 held, then flush=1 with new_pc=0x20 and stall[0]=1 on the same cycle as a live branch to 0x300. Required: pc=0x20 next cycle, pending cleared, 0x300 never appears.
- Back-pressure and wrap: pc=0xFFFF_FFFC with imem_ready=0 for 2 cycles. Required: pc holds at 0xFFFF_FFFC; when imem_ready=1, pc=0x0000_0000.
- Misaligned target: branch to 0x0000_0102 with adv=1. Required: pc=0x100, misalign=1 for exactly one cycle, misalign_addr=0x102. Repeat with FETCH_BYTES=8 and target 0x104: pc=0x100, misalign pulses once.
- Async reset mid-run: rst=0 asserted between clock edges while pending=1. Required: ce=0, pc=RESET_PC and redirect_pending=0 without waiting for a clock edge.
